// File: rtl/snake_pkg.sv
// Shared definitions for the snake movement core.
// Holds the direction, collision-cause and FSM state encodings, and a
// helper that returns the opposite heading.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_WALL = 2'd1,
        CAUSE_SELF = 2'd2
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    // Opposite heading; a request for it would fold the snake onto itself.
    function automatic dir_e reverse_dir(input dir_e d);
        dir_e r;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            default:   r = DIR_UP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_seg_match.sv
// Parallel compare of one cell coordinate against every stored segment.
// Only segments below len take part; with excl_tail set, the last live
// segment (index len-1) is also ignored because it vacates on a plain move.
// Ports:
//   seg_x/seg_y : segment coordinate arrays, index 0 is the head
//   len         : number of live segments
//   excl_tail   : ignore segment len-1
//   x/y         : cell under test
//   hit         : cell matches any considered segment
//   hit_head    : cell matches the head segment
module snake_seg_match #(
    parameter int MAX_LEN = 64,
    parameter int XW      = 6,
    parameter int YW      = 5,
    parameter int LW      = 7
) (
    input  logic [XW-1:0] seg_x [MAX_LEN],
    input  logic [YW-1:0] seg_y [MAX_LEN],
    input  logic [LW-1:0] len,
    input  logic          excl_tail,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic          hit,
    output logic          hit_head
);

    // OR-reduce the per-segment matches under the length and tail masks.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            hit = hit | ((seg_x[i] == x) && (seg_y[i] == y) &&
                         (LW'(i) < len) &&
                         !(excl_tail && (LW'(i + 1) == len)));
        end
        hit_head = (seg_x[0] == x) && (seg_y[0] == y) && (len != LW'(0));
    end

endmodule

// File: rtl/snake_body_engine.sv
// Snake movement/body core on a GRID_W x GRID_H cell grid.
// Keeps up to MAX_LEN segment coordinates, applies buffered direction
// changes on each move tick, grows on food, detects wall and self
// collisions (or wraps in WRAP_MODE=1) and answers a registered per-cell
// query for the display.
// Ports:
//   clk, reset (async, active low), start, tick
//   dir_valid/dir_req   : direction request
//   food_x/food_y       : food cell
//   query_x/query_y     : display cell to look up
//   head_x/head_y, length, ate, game_over, over_cause
//   query_hit/query_head: lookup result, one clock after the query
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int XW        = 6,
    parameter int YW        = 5,
    parameter int MAX_LEN   = 64,
    parameter int INIT_LEN  = 3,
    parameter int WRAP_MODE = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         tick,
    input  logic                         dir_valid,
    input  logic [1:0]                   dir_req,
    input  logic [XW-1:0]                food_x,
    input  logic [YW-1:0]                food_y,
    input  logic [XW-1:0]                query_x,
    input  logic [YW-1:0]                query_y,
    output logic [XW-1:0]                head_x,
    output logic [YW-1:0]                head_y,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic                         ate,
    output logic                         game_over,
    output logic [1:0]                   over_cause,
    output logic                         query_hit,
    output logic                         query_head
);

    localparam int LW        = $clog2(MAX_LEN + 1);
    localparam bit WALL_KILL = (WRAP_MODE == 32'sd0);

    // Start-of-game body: a horizontal line ending at the grid centre.
    function automatic logic [XW-1:0] init_x(input int i);
        return (i < INIT_LEN) ? XW'(GRID_W / 2 - i) : XW'(32'd0);
    endfunction

    function automatic logic [YW-1:0] init_y(input int i);
        return (i < INIT_LEN) ? YW'(GRID_H / 2) : YW'(32'd0);
    endfunction

    state_e        state_r, next_state_s;
    logic [XW-1:0] seg_x_r [MAX_LEN];
    logic [YW-1:0] seg_y_r [MAX_LEN];
    logic [LW-1:0] len_r;
    dir_e          heading_r, pending_r, eff_dir_s, ref_dir_s;
    logic          pending_valid_r;
    logic          ate_r, game_over_r, query_hit_r, query_head_r;
    cause_e        cause_r;
    logic [XW-1:0] nx_s;
    logic [YW-1:0] ny_s;
    logic          wall_s, eat_s, self_s, step_s, restart_s, dir_accept_s;
    logic          col_any_s, col_head_s, q_hit_s, q_head_s;

    assign step_s    = tick && (state_r == ST_RUN);
    assign restart_s = start && (state_r != ST_RUN);
    // The move on a tick already uses a buffered request.
    assign eff_dir_s = pending_valid_r ? pending_r : heading_r;
    // A request arriving with a tick is judged against the heading it will follow.
    assign ref_dir_s = step_s ? eff_dir_s : heading_r;
    assign dir_accept_s = dir_valid && (dir_e'(dir_req) != reverse_dir(ref_dir_s));
    assign eat_s     = (nx_s == food_x) && (ny_s == food_y);
    // Head match is a subset of the body match; folding it in keeps both used.
    assign self_s    = col_any_s | col_head_s;

    // Next head cell and edge handling (death or wrap).
    always_comb begin
        nx_s   = seg_x_r[0];
        ny_s   = seg_y_r[0];
        wall_s = 1'b0;
        case (eff_dir_s)
            DIR_UP: begin
                if (seg_y_r[0] == YW'(0)) begin
                    ny_s   = YW'(GRID_H - 1);
                    wall_s = WALL_KILL;
                end else begin
                    ny_s = seg_y_r[0] - YW'(1);
                end
            end
            DIR_DOWN: begin
                if (seg_y_r[0] == YW'(GRID_H - 1)) begin
                    ny_s   = YW'(0);
                    wall_s = WALL_KILL;
                end else begin
                    ny_s = seg_y_r[0] + YW'(1);
                end
            end
            DIR_LEFT: begin
                if (seg_x_r[0] == XW'(0)) begin
                    nx_s   = XW'(GRID_W - 1);
                    wall_s = WALL_KILL;
                end else begin
                    nx_s = seg_x_r[0] - XW'(1);
                end
            end
            DIR_RIGHT: begin
                if (seg_x_r[0] == XW'(GRID_W - 1)) begin
                    nx_s   = XW'(0);
                    wall_s = WALL_KILL;
                end else begin
                    nx_s = seg_x_r[0] + XW'(1);
                end
            end
            default: begin
                nx_s = seg_x_r[0];
            end
        endcase
    end

    snake_seg_match #(.MAX_LEN(MAX_LEN), .XW(XW), .YW(YW), .LW(LW)) u_col_match (
        .seg_x     (seg_x_r),
        .seg_y     (seg_y_r),
        .len       (len_r),
        .excl_tail (!eat_s),
        .x         (nx_s),
        .y         (ny_s),
        .hit       (col_any_s),
        .hit_head  (col_head_s)
    );

    snake_seg_match #(.MAX_LEN(MAX_LEN), .XW(XW), .YW(YW), .LW(LW)) u_query_match (
        .seg_x     (seg_x_r),
        .seg_y     (seg_y_r),
        .len       (len_r),
        .excl_tail (1'b0),
        .x         (query_x),
        .y         (query_y),
        .hit       (q_hit_s),
        .hit_head  (q_head_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: next_state_s = start ? ST_RUN : ST_IDLE;
            ST_RUN:  next_state_s = (step_s && (wall_s || self_s)) ? ST_OVER : ST_RUN;
            ST_OVER: next_state_s = start ? ST_RUN : ST_OVER;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Body, heading buffer and status registers; start re-initialises everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_r[i] <= init_x(i);
                seg_y_r[i] <= init_y(i);
            end
            len_r           <= LW'(INIT_LEN);
            heading_r       <= DIR_RIGHT;
            pending_r       <= DIR_RIGHT;
            pending_valid_r <= 1'b0;
            ate_r           <= 1'b0;
            game_over_r     <= 1'b0;
            cause_r         <= CAUSE_NONE;
        end else if (restart_s) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_r[i] <= init_x(i);
                seg_y_r[i] <= init_y(i);
            end
            len_r           <= LW'(INIT_LEN);
            heading_r       <= DIR_RIGHT;
            pending_r       <= DIR_RIGHT;
            pending_valid_r <= 1'b0;
            ate_r           <= 1'b0;
            game_over_r     <= 1'b0;
            cause_r         <= CAUSE_NONE;
        end else begin
            ate_r <= 1'b0;
            if (step_s) begin
                heading_r       <= eff_dir_s;
                pending_valid_r <= 1'b0;
            end
            // A request in the tick cycle lands after the clear above.
            if (dir_accept_s) begin
                pending_r       <= dir_e'(dir_req);
                pending_valid_r <= 1'b1;
            end
            if (step_s) begin
                if (wall_s || self_s) begin
                    game_over_r <= 1'b1;
                    cause_r     <= wall_s ? CAUSE_WALL : CAUSE_SELF;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x_r[i] <= seg_x_r[i-1];
                        seg_y_r[i] <= seg_y_r[i-1];
                    end
                    seg_x_r[0] <= nx_s;
                    seg_y_r[0] <= ny_s;
                    ate_r      <= eat_s;
                    if (eat_s && (len_r != LW'(MAX_LEN))) begin
                        len_r <= len_r + LW'(1);
                    end
                end
            end
        end
    end

    // Display lookup, registered every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            query_hit_r  <= 1'b0;
            query_head_r <= 1'b0;
        end else begin
            query_hit_r  <= q_hit_s;
            query_head_r <= q_head_s;
        end
    end

    assign head_x     = seg_x_r[0];
    assign head_y     = seg_y_r[0];
    assign length     = len_r;
    assign ate        = ate_r;
    assign game_over  = game_over_r;
    assign over_cause = cause_r;
    assign query_hit  = query_hit_r;
    assign query_head = query_head_r;

endmodule

// File: tb/tb_snake_body_engine.sv
// Self-checking bench for snake_body_engine.
// Three instances share one stimulus: default (wall kills), wrap mode, and
// MAX_LEN=4. A table of per-cycle vectors drives the default instance;
// short hand-written sequences cover walls, wrap, saturation and async reset.
module tb_snake_body_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, tick, dir_valid;
    logic [1:0] dir_req;
    logic [5:0] food_x, query_x;
    logic [4:0] food_y, query_y;

    logic [5:0] d_hx, w_hx, s_hx;
    logic [4:0] d_hy, w_hy, s_hy;
    logic [6:0] d_len, w_len;
    logic [2:0] s_len;
    logic       d_ate, w_ate, s_ate, d_go, w_go, s_go;
    logic [1:0] d_c, w_c, s_c;
    logic       d_qh, w_qh, s_qh, d_qd, w_qd, s_qd;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    snake_body_engine dut (
        .clk(clk), .reset(rst_n), .start(start), .tick(tick),
        .dir_valid(dir_valid), .dir_req(dir_req), .food_x(food_x), .food_y(food_y),
        .query_x(query_x), .query_y(query_y), .head_x(d_hx), .head_y(d_hy),
        .length(d_len), .ate(d_ate), .game_over(d_go), .over_cause(d_c),
        .query_hit(d_qh), .query_head(d_qd)
    );

    snake_body_engine #(.WRAP_MODE(1)) dut_wrap (
        .clk(clk), .reset(rst_n), .start(start), .tick(tick),
        .dir_valid(dir_valid), .dir_req(dir_req), .food_x(food_x), .food_y(food_y),
        .query_x(query_x), .query_y(query_y), .head_x(w_hx), .head_y(w_hy),
        .length(w_len), .ate(w_ate), .game_over(w_go), .over_cause(w_c),
        .query_hit(w_qh), .query_head(w_qd)
    );

    snake_body_engine #(.MAX_LEN(4)) dut_small (
        .clk(clk), .reset(rst_n), .start(start), .tick(tick),
        .dir_valid(dir_valid), .dir_req(dir_req), .food_x(food_x), .food_y(food_y),
        .query_x(query_x), .query_y(query_y), .head_x(s_hx), .head_y(s_hy),
        .length(s_len), .ate(s_ate), .game_over(s_go), .over_cause(s_c),
        .query_hit(s_qh), .query_head(s_qd)
    );

    typedef struct {
        logic       st, tk, dv;
        logic [1:0] d;
        logic [5:0] fx, qx;
        logic [4:0] fy, qy;
        int         hx, hy, ln, a, go, c, qh, qd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input int st, tk, dv, d, fx, fy, qx, qy,
                               input int hx, hy, ln, a, go, c, qh, qd);
        vec_t r;
        r.st = st[0]; r.tk = tk[0]; r.dv = dv[0]; r.d = d[1:0];
        r.fx = fx[5:0]; r.fy = fy[4:0]; r.qx = qx[5:0]; r.qy = qy[4:0];
        r.hx = hx; r.hy = hy; r.ln = ln; r.a = a; r.go = go; r.c = c; r.qh = qh; r.qd = qd;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start = 1'b0; tick = 1'b0; dir_valid = 1'b0; dir_req = 2'd0;
        food_x = 6'd0; food_y = 5'd0; query_x = 6'd0; query_y = 5'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_in();
        cyc();
        rst_n = 1'b1;
    endtask

    // Safety net in case the clock or a sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directions: 0 up, 1 down, 2 left, 3 right. Food (0,0) is never reached.
        //               st tk dv d  fx fy qx qy   hx hy ln a go c qh qd
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 19, 15, 20, 15, 3, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 20, 15, 20, 15, 3, 0, 0, 0, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 18, 15, 20, 15, 3, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 17, 15, 20, 15, 3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 2, 0, 0,  0,  0, 20, 15, 3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  0,  0, 21, 15, 3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 0,  0,  0, 21, 15, 3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  0,  0, 21, 14, 3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 21, 13, 0, 0, 21, 13, 4, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 20, 15, 21, 13, 4, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 21, 13, 21, 13, 4, 0, 0, 0, 1, 1));
        tbl.push_back(v(0, 0, 1, 3, 0, 0,  0,  0, 21, 13, 4, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 22, 13, 0, 0, 22, 13, 5, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, 0, 0,  0,  0, 22, 13, 5, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  0,  0, 22, 14, 5, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 2, 0, 0,  0,  0, 22, 14, 5, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  0,  0, 22, 14, 5, 0, 1, 2, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  0,  0, 22, 14, 5, 0, 1, 2, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 21, 15, 22, 14, 5, 0, 1, 2, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,  0,  0, 20, 15, 3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 21, 15, 0, 0, 21, 15, 4, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 18, 15, 21, 15, 4, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 1, 0, 0,  0,  0, 21, 15, 4, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  0,  0, 21, 16, 4, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 2, 0, 0,  0,  0, 21, 16, 4, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  0,  0, 20, 16, 4, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 0,  0,  0, 20, 16, 4, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  0,  0, 20, 15, 4, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 20, 16, 20, 15, 4, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 19, 15, 20, 15, 4, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 20, 15, 20, 15, 4, 0, 0, 0, 1, 1));

        // Reset state.
        rst_n = 1'b0;
        idle_in();
        cyc();
        chk("rst_hx", d_hx, 20);   chk("rst_hy", d_hy, 15);
        chk("rst_len", d_len, 3);  chk("rst_ate", d_ate, 0);
        chk("rst_go", d_go, 0);    chk("rst_cause", d_c, 0);
        chk("rst_qhit", d_qh, 0);  chk("rst_qhead", d_qd, 0);
        rst_n = 1'b1;

        // Table: one vector per clock on the default instance.
        for (int k = 0; k < tbl.size(); k++) begin
            start = tbl[k].st; tick = tbl[k].tk; dir_valid = tbl[k].dv; dir_req = tbl[k].d;
            food_x = tbl[k].fx; food_y = tbl[k].fy; query_x = tbl[k].qx; query_y = tbl[k].qy;
            cyc();
            chk($sformatf("v%0d_hx", k), d_hx, tbl[k].hx);
            chk($sformatf("v%0d_hy", k), d_hy, tbl[k].hy);
            chk($sformatf("v%0d_len", k), d_len, tbl[k].ln);
            chk($sformatf("v%0d_ate", k), d_ate, tbl[k].a);
            chk($sformatf("v%0d_go", k), d_go, tbl[k].go);
            chk($sformatf("v%0d_cause", k), d_c, tbl[k].c);
            chk($sformatf("v%0d_qhit", k), d_qh, tbl[k].qh);
            chk($sformatf("v%0d_qhead", k), d_qd, tbl[k].qd);
        end
        idle_in();

        // Right wall: 19 moves reach x=39, the 20th hits the wall or wraps.
        do_reset();
        start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1;
        repeat (19) cyc();
        chk("wall_pre_hx", d_hx, 39);  chk("wall_pre_go", d_go, 0);
        chk("wrap_pre_hx", w_hx, 39);
        cyc();
        chk("wall_go", d_go, 1);       chk("wall_cause", d_c, 1);
        chk("wall_hx", d_hx, 39);      chk("wall_hy", d_hy, 15);
        chk("wrap_hx", w_hx, 0);       chk("wrap_go", w_go, 0);
        chk("wrap_cause", w_c, 0);
        cyc();
        chk("wrap_hx2", w_hx, 1);      chk("wall_hx2", d_hx, 39);
        tick = 1'b0;

        // Asynchronous reset in the middle of a cycle while running.
        tick = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_hx", w_hx, 20);      chk("arst_hy", w_hy, 15);
        chk("arst_len", w_len, 3);     chk("arst_ate", w_ate, 0);
        chk("arst_go", d_go, 0);       chk("arst_cause", d_c, 0);
        chk("arst_qhit", w_qh, 0);     chk("arst_qhead", w_qd, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("idle_tick_hx", w_hx, 20); chk("idle_tick_len", w_len, 3);
        tick = 1'b0;

        // Length saturation at MAX_LEN=4: both meals pulse ate, tail drops.
        do_reset();
        start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1; food_x = 6'd21; food_y = 5'd15;
        cyc();
        chk("sat1_ate", s_ate, 1);     chk("sat1_len", s_len, 4);
        chk("sat1_hx", s_hx, 21);
        food_x = 6'd22;
        cyc();
        chk("sat2_ate", s_ate, 1);     chk("sat2_len", s_len, 4);
        chk("sat2_hx", s_hx, 22);      chk("grow_len", d_len, 5);
        tick = 1'b0; food_x = 6'd0; food_y = 5'd0;
        query_x = 6'd18; query_y = 5'd15;
        cyc();
        chk("sat_ate_off", s_ate, 0);  chk("sat_tail_gone", s_qh, 0);
        chk("grow_tail_kept", d_qh, 1);
        query_x = 6'd19;
        cyc();
        chk("sat_tail_new", s_qh, 1);
        idle_in();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
